// File: rtl/otp_frame_tx.sv
// UART 8N1 framer for OTP ciphertext: FIFO of {index,data}; each entry goes out as header then payload.
// Optional FRAME_CHECKSUM_EN appends a third byte CHK = header ^ payload to every entry.
module otp_frame_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic [2:0]                    in_index,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

`ifdef FRAME_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

  logic [10:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [1:0]     state;
  logic [BCW-1:0] baud_cnt;
  logic [2:0]     bit_cnt;
  logic [1:0]     byte_sel;
  logic [7:0]     shreg;
  logic [7:0]     pay;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]     hdr;
`endif

  logic        push, pop, bit_end, entry_done;
  logic [10:0] head;
  logic [7:0]  head_hdr, next_byte;

  assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign busy       = (state != IDLE);
  assign push       = in_valid & ena & in_ready;
  assign bit_end    = (state != IDLE) && (baud_cnt == BCW'(CLKS_PER_BIT - 1));
  assign entry_done = (state == STOP) && bit_end && (byte_sel == LAST_BYTE);
  // A new entry may only start from IDLE or right at the end of the previous entry's last stop bit
  assign pop        = ena && (fifo_count != '0) && ((state == IDLE) || entry_done);
  assign head       = mem[rd_ptr];
  assign head_hdr   = {4'hA, 1'b0, head[10:8]};

  always_comb begin
    next_byte = pay;
`ifdef FRAME_CHECKSUM_EN
    if (byte_sel == 2'd1) next_byte = hdr ^ pay;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_index, in_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (in_valid && ena && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_sel <= '0;
      shreg    <= '0;
      pay      <= '0;
`ifdef FRAME_CHECKSUM_EN
      hdr      <= '0;
`endif
    end else if (pop) begin
      state    <= START;
      tx       <= 1'b0;
      baud_cnt <= '0;
      byte_sel <= '0;
      shreg    <= head_hdr;
      pay      <= head[7:0];
`ifdef FRAME_CHECKSUM_EN
      hdr      <= head_hdr;
`endif
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= shreg[0];
          bit_cnt <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            tx      <= shreg[1];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: if (bit_end) begin
          if (byte_sel != LAST_BYTE) begin
            state    <= START;
            tx       <= 1'b0;
            shreg    <= next_byte;
            byte_sel <= byte_sel + 1'b1;
          end else begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_otp_frame_tx.sv
// Self-checking bench for otp_frame_tx: per-cycle compare against a queue-based line model plus directed literals.
module tb_otp_frame_tx;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif
  localparam int FRAME = NBYTES * 10 * CPB;

  logic       clk = 0, rst_n = 0, ena = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic [2:0] in_index = 0;
  logic       in_ready, tx, busy, overflow;
  logic [2:0] fifo_count;

  otp_frame_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .in_index(in_index), .in_ready(in_ready), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of entries and a queue of per-cycle line levels for the entry in flight
  logic [10:0] fq[$];
  bit          line[$];
  bit          m_tx = 1, m_busy = 0, m_ovf = 0;
  bit          m_pop, m_can_push;
  logic [10:0] m_e;

  task automatic add_byte(input logic [7:0] b);
    repeat (CPB) line.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) line.push_back(b[i]);
    repeat (CPB) line.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete(); line.delete();
      m_tx = 1; m_busy = 0; m_ovf = 0;
    end else begin
      m_pop      = (line.size() == 0) && (fq.size() > 0) && ena;
      m_can_push = fq.size() < DEPTH;
      if (in_valid && ena && !m_can_push) m_ovf = 1;
      if (m_pop) begin
        m_e = fq.pop_front();
        add_byte({4'hA, 1'b0, m_e[10:8]});
        add_byte(m_e[7:0]);
        if (NBYTES == 3) add_byte({4'hA, 1'b0, m_e[10:8]} ^ m_e[7:0]);
      end
      if (in_valid && ena && m_can_push) fq.push_back({in_index, in_data});
      if (line.size() > 0) begin m_tx = line.pop_front(); m_busy = 1; end
      else begin m_tx = 1; m_busy = 0; end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("cyc_tx", tx, m_tx);
    check("cyc_busy", busy, m_busy);
    check("cyc_count", fifo_count, fq.size());
    check("cyc_ready", in_ready, fq.size() < DEPTH);
    check("cyc_overflow", overflow, m_ovf);
  end

  bit samp[FRAME];

  task automatic push1(input logic [7:0] d, input logic [2:0] idx);
    in_valid = 1; in_data = d; in_index = idx;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    int g = 0;
    while (busy && g < bound) begin @(negedge clk); g++; end
    check("idle_timeout", int'(g < bound), 1);
  endtask

  // Capture one frame starting at the current negedge (first sample = start bit) and decode it
  task automatic grab_and_decode(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_b[3];
    logic [7:0] got;
    exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2;
    samp[0] = tx;
    for (int i = 1; i < FRAME; i++) begin @(negedge clk); samp[i] = tx; end
    for (int k = 0; k < NBYTES; k++) begin
      for (int i = 0; i < 8; i++) got[i] = samp[k*10*CPB + (i+1)*CPB + CPB/2];
      check("dec_start", samp[k*10*CPB + CPB/2], 0);
      check("dec_byte", got, exp_b[k]);
      check("dec_stop", samp[k*10*CPB + 9*CPB + CPB/2], 1);
    end
    @(negedge clk);
    check("frame_end_busy", busy, 0);
  endtask

  int busy_cnt, g;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1; rst_n = 1; ena = 1;

    // 1: idle after reset
    repeat (50) @(negedge clk);
    check("idle_tx", tx, 1); check("idle_busy", busy, 0);
    check("idle_count", fifo_count, 0); check("idle_ovf", overflow, 0);
    check("idle_ready", in_ready, 1);

    // 2: single entry, latency and byte decode
    push1(8'h3C, 3'd5);
    check("lat_tx_hi", tx, 1);
    @(negedge clk);
    check("lat_tx_lo", tx, 0);
    grab_and_decode(8'hA5, 8'h3C, 8'hA5 ^ 8'h3C);

    // 3: seven back-to-back pushes, two rejected, five contiguous frames
    busy_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1; in_data = 8'($urandom); in_index = 3'($urandom);
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    in_valid = 0;
    g = 0;
    while (busy && g < 8 * FRAME) begin @(negedge clk); g++; if (busy) busy_cnt++; end
    check("burst_busy_cycles", busy_cnt, 5 * FRAME);
    check("burst_overflow", overflow, 1);
    rst_n = 0; @(negedge clk); rst_n = 1;
    check("ovf_cleared", overflow, 0);

    // 4: ena drop during payload keeps queue, re-raise starts next frame immediately
    push1(8'h11, 3'd1); push1(8'h22, 3'd2); push1(8'h33, 3'd3);
    repeat (10 * CPB + 6) @(negedge clk);
    ena = 0;
    wait_idle(2 * FRAME);
    check("ena_count", fifo_count, 2); check("ena_tx", tx, 1);
    repeat (10) @(negedge clk);
    check("ena_hold_busy", busy, 0); check("ena_hold_count", fifo_count, 2);
    ena = 1;
    @(negedge clk);
    check("ena_restart_tx", tx, 0); check("ena_restart_busy", busy, 1);

    // 5: reset mid-DATA drops everything
    push1(8'h44, 3'd4);
    repeat (CPB + 3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("rst_tx", tx, 1); check("rst_busy", busy, 0); check("rst_count", fifo_count, 0);
    rst_n = 1;
    repeat (FRAME) @(negedge clk);
    check("rst_nothing_sent", busy, 0);

`ifdef FRAME_CHECKSUM_EN
    // 6: checksum byte
    push1(8'hFF, 3'd2);
    @(negedge clk);
    grab_and_decode(8'hA2, 8'hFF, 8'h5D);
`endif

    // Randomized traffic with ena toggling and occasional resets
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom_range(0, 99) < 12);
      in_data = 8'($urandom); in_index = 3'($urandom);
      if ($urandom_range(0, 99) < 2) ena = ~ena;
      rst_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    in_valid = 0; rst_n = 1; ena = 1;
    g = 0;
    while ((busy || fifo_count != 0) && g < 8 * FRAME) begin @(negedge clk); g++; end
    check("drain_timeout", int'(g < 8 * FRAME), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
